// File: rtl/alu_ctrl_seq_if.sv
// Bundle of the fetch handshake, register-file ports and ALU port seen by the
// issue sequencer; master is the sequencer, slave is the surrounding datapath.
interface alu_ctrl_seq_if #(
   parameter int DATA_W = 8,
   parameter int RA_W   = 2
);
   logic [15:0]       instr;
   logic              instr_valid;
   logic              instr_ready;
   logic [RA_W-1:0]   ra1;
   logic [RA_W-1:0]   ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [2:0]        op_alu;
   logic [DATA_W-1:0] alu_y;
   logic              alu_zero;
   logic [RA_W-1:0]   wa;
   logic [DATA_W-1:0] wd;
   logic              we;
   logic              zf;
   logic              done;
   logic              err;

   modport master (
      input  instr, instr_valid, rd1, rd2, alu_y, alu_zero,
      output instr_ready, ra1, ra2, alu_a, alu_b, op_alu, wa, wd, we, zf, done, err
   );

   modport slave (
      output instr, instr_valid, rd1, rd2, alu_y, alu_zero,
      input  instr_ready, ra1, ra2, alu_a, alu_b, op_alu, wa, wd, we, zf, done, err
   );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Four-state issue sequencer (IDLE -> READ -> EXEC -> WB): reads operands,
// drives the external ALU from registers, writes back y and latches the zero flag.
module alu_ctrl_seq #(
   parameter int DATA_W = 8,
   parameter int RA_W   = 2
) (
   input  logic          clk,
   input  logic          reset,
   alu_ctrl_seq_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   state_t            state_q, state_d;
   logic [15:0]       instr_q, instr_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] y_q, y_d;
   logic              zero_q, zero_d;
   logic              zf_q, zf_d;

   logic [3:0]        opc;
   logic [2:0]        dec_op;
   logic              dec_write;
   logic              illegal;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;
   logic [DATA_W-1:0] imm;
   logic              in_wb;

   assign opc = instr_q[15:12];
   assign imm = DATA_W'(instr_q[7:0]);

   // Decode of the latched instruction; opcodes above ADDI are illegal.
   always_comb begin
      dec_op    = 3'b000;
      dec_write = 1'b0;
      illegal   = 1'b0;
      opnd_a    = bus.rd1;
      opnd_b    = bus.rd2;
      unique casez (opc)
         4'b0???: begin
            dec_op    = opc[2:0];
            dec_write = 1'b1;
         end
         4'b1000: dec_op = 3'b011;
         4'b1001: begin
            dec_write = 1'b1;
            opnd_a    = imm;
            opnd_b    = '0;
         end
         4'b1010: begin
            dec_op    = 3'b010;
            dec_write = 1'b1;
            opnd_b    = imm;
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      op_d    = op_q;
      y_d     = y_q;
      zero_d  = zero_q;
      zf_d    = zf_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               instr_d = bus.instr;
               state_d = S_READ;
            end
         end
         S_READ: begin
            // ALU inputs are loaded here so they are stable for all of EXEC.
            alu_a_d = opnd_a;
            alu_b_d = opnd_b;
            op_d    = dec_op;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            y_d     = bus.alu_y;
            zero_d  = bus.alu_zero;
            state_d = S_WB;
         end
         S_WB: begin
            if (!illegal) zf_d = zero_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         alu_a_q <= '0;
         alu_b_q <= '0;
         op_q    <= '0;
         y_q     <= '0;
         zero_q  <= 1'b0;
         zf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         op_q    <= op_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
         zf_q    <= zf_d;
      end
   end

   // Outputs are decoded from registered state only, so rd1/rd2 never loop back.
   assign in_wb           = (state_q == S_WB);
   assign bus.instr_ready = (state_q == S_IDLE);
   assign bus.ra1         = (state_q == S_READ) ? RA_W'(instr_q[9:8]) : '0;
   assign bus.ra2         = (state_q == S_READ) ? RA_W'(instr_q[7:6]) : '0;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.op_alu      = op_q;
   assign bus.we          = in_wb && !illegal && dec_write;
   assign bus.wa          = bus.we ? RA_W'(instr_q[11:10]) : '0;
   assign bus.wd          = bus.we ? y_q : '0;
   assign bus.zf          = zf_q;
   assign bus.done        = in_wb && !illegal;
   assign bus.err         = in_wb && illegal;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with a behavioural register file and ALU.
module tb_alu_ctrl_seq;
   localparam int DATA_W = 8;
   localparam int RA_W   = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_ctrl_seq_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus ();

   alu_ctrl_seq #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // Environment: register file (combinational read) and 8-bit ALU.
   logic [7:0] rf [4];
   logic [7:0] alu_y;
   assign bus.rd1 = rf[bus.ra1];
   assign bus.rd2 = rf[bus.ra2];
   always @(posedge clk) if (bus.we) rf[bus.wa] <= bus.wd;

   always_comb begin
      alu_y = 8'h00;
      case (bus.op_alu)
         3'b000: alu_y = bus.alu_a;
         3'b001: alu_y = ~bus.alu_a;
         3'b010: alu_y = bus.alu_a + bus.alu_b;
         3'b011: alu_y = bus.alu_a - bus.alu_b;
         3'b100: alu_y = bus.alu_a & bus.alu_b;
         3'b101: alu_y = bus.alu_a | bus.alu_b;
         3'b110: alu_y = 8'h00 - bus.alu_a;
         default: alu_y = 8'h00 - bus.alu_b;
      endcase
   end
   assign bus.alu_y    = alu_y;
   assign bus.alu_zero = (alu_y == 8'h00);

   typedef struct {
      logic [15:0] instr;
      logic        we;
      logic [1:0]  wa;
      logic [7:0]  wd;
      logic        zf;
      logic        err;
   } vec_t;

   vec_t vecs [15];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic [15:0] instr, input logic we, input logic [1:0] wa,
                               input logic [7:0] wd, input logic zf, input logic err);
      vec_t v;
      v.instr = instr; v.we = we; v.wa = wa; v.wd = wd; v.zf = zf; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      int t = 0;
      while (!bus.instr_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({name, ".ready"}, 32'(bus.instr_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      wait_ready(name);
      bus.instr       = v.instr;
      bus.instr_valid = 1'b1;
      @(negedge clk);                       // READ
      bus.instr_valid = 1'b0;
      bus.instr       = 16'hFFFF;
      chk({name, ".busy"}, 32'(bus.instr_ready), 32'd0);
      chk({name, ".done_c1"}, 32'(bus.done), 32'd0);
      @(negedge clk);                       // EXEC
      chk({name, ".done_c2"}, 32'(bus.done | bus.we), 32'd0);
      @(negedge clk);                       // WB
      chk({name, ".we"}, 32'(bus.we), 32'(v.we));
      chk({name, ".wa"}, 32'(bus.wa), 32'(v.wa));
      chk({name, ".wd"}, 32'(bus.wd), 32'(v.wd));
      chk({name, ".done"}, 32'(bus.done), 32'(!v.err));
      chk({name, ".err"}, 32'(bus.err), 32'(v.err));
      @(negedge clk);                       // back in IDLE
      chk({name, ".zf"}, 32'(bus.zf), 32'(v.zf));
      chk({name, ".done_c4"}, 32'(bus.done | bus.err), 32'd0);
      chk({name, ".ready_c4"}, 32'(bus.instr_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc [$];
      logic [7:0]  wr [$];
      int          n_we;

      reset           = 1'b1;
      bus.instr       = 16'h0000;
      bus.instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.ready", 32'(bus.instr_ready), 32'd1);
      chk("rst.we_done_err", 32'({bus.we, bus.done, bus.err}), 32'd0);
      chk("rst.zf", 32'(bus.zf), 32'd0);
      chk("rst.op_alu", 32'(bus.op_alu), 32'd0);
      chk("rst.alu_ab", 32'({bus.alu_a, bus.alu_b}), 32'd0);
      chk("rst.wa_wd", 32'({bus.wa, bus.wd}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      vecs[0]  = mk(16'h9405, 1'b1, 2'd1, 8'h05, 1'b0, 1'b0); // LDI  r1,0x05
      vecs[1]  = mk(16'h2940, 1'b1, 2'd2, 8'h0A, 1'b0, 1'b0); // ADD  r2,r1,r1
      vecs[2]  = mk(16'h9CFF, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0); // LDI  r3,0xFF
      vecs[3]  = mk(16'h9001, 1'b1, 2'd0, 8'h01, 1'b0, 1'b0); // LDI  r0,0x01
      vecs[4]  = mk(16'h2B00, 1'b1, 2'd2, 8'h00, 1'b1, 1'b0); // ADD  r2,r3,r0 wraps
      vecs[5]  = mk(16'h8140, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0); // CMP  r1,r1
      vecs[6]  = mk(16'h6C00, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0); // NEGA r3,r0
      vecs[7]  = mk(16'h3140, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0); // SUB  r0,r1,r1
      vecs[8]  = mk(16'hC000, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1); // illegal, zf kept
      vecs[9]  = mk(16'h4B40, 1'b1, 2'd2, 8'h05, 1'b0, 1'b0); // AND  r2,r3,r1
      vecs[10] = mk(16'h51C0, 1'b1, 2'd0, 8'hFF, 1'b0, 1'b0); // OR   r0,r1,r3
      vecs[11] = mk(16'h1100, 1'b1, 2'd0, 8'hFA, 1'b0, 1'b0); // NOT  r0,r1
      vecs[12] = mk(16'hA5FB, 1'b1, 2'd1, 8'h00, 1'b1, 1'b0); // ADDI r1,r1,0xFB
      vecs[13] = mk(16'h78C0, 1'b1, 2'd2, 8'h01, 1'b0, 1'b0); // NEGB r2,-,r3
      vecs[14] = mk(16'h0E00, 1'b1, 2'd3, 8'h01, 1'b0, 1'b0); // MOV  r3,r2

      for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // instr_valid held for 8 cycles with instr changing every cycle.
      for (int c = 0; c < 12; c++) begin
         bus.instr_valid = (c < 8);
         bus.instr       = {8'h90, 8'(8'h10 + c)};
         #1;
         if (bus.instr_valid && bus.instr_ready) acc.push_back(c);
         if (bus.we) wr.push_back(bus.wd);
         @(negedge clk);
      end
      bus.instr_valid = 1'b0;
      chk("hold.accepts", 32'(acc.size()), 32'd2);
      if (acc.size() == 2) begin
         chk("hold.first", 32'(acc[0]), 32'd0);
         chk("hold.spacing", 32'(acc[1] - acc[0]), 32'd4);
      end
      chk("hold.writes", 32'(wr.size()), 32'd2);
      if (wr.size() == 2) begin
         chk("hold.wd0", 32'(wr[0]), 32'h10);
         chk("hold.wd1", 32'(wr[1]), 32'h14);
      end

      // Reset during EXEC of ADD r2,r0,r0 aborts it and clears zf.
      run_vec(mk(16'h8140, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0), "cmp_pre");
      wait_ready("rst_exec");
      bus.instr       = 16'h2800;
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("rst_exec.op_alu", 32'(bus.op_alu), 32'd2);
      chk("rst_exec.alu_a", 32'(bus.alu_a), 32'h14);
      #2 reset = 1'b1;
      #1;
      chk("rst_exec.ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_exec.we_done", 32'({bus.we, bus.done}), 32'd0);
      chk("rst_exec.zf", 32'(bus.zf), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      n_we  = 0;
      for (int c = 0; c < 4; c++) begin
         if (bus.we || bus.done) n_we++;
         @(negedge clk);
      end
      chk("rst_exec.no_wb", 32'(n_we), 32'd0);
      chk("rst_exec.r2_kept", 32'(rf[2]), 32'h01);
      run_vec(mk(16'h985A, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b0), "after_rst");
      chk("after_rst.r2", 32'(rf[2]), 32'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
